// File: rtl/stim_lfsr_gen_if.sv
// Stimulus bundle between the LFSR generator and its consumer.
// The generator takes the master side and the bench the slave side.
interface stim_lfsr_gen_if #(
   parameter int WIDTH   = 8,
   parameter int NUM_VEC = 16
);
   localparam int CNT_W = $clog2(NUM_VEC + 1);

   logic             start;
   logic             hold;
   logic [WIDTH-1:0] stim;
   logic             valid;
   logic             chk_stb;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] count;

   modport master (
      input  start, hold,
      output stim, valid, chk_stb, busy, done, count
   );

   modport slave (
      output start, hold,
      input  stim, valid, chk_stb, busy, done, count
   );
endinterface

// File: rtl/stim_lfsr_gen.sv
// Bounded-run Galois LFSR stimulus source with a trailing check strobe.
// A small IDLE/RUN/DONE FSM starts, pauses and ends each run.
module stim_lfsr_gen #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] TAPS    = 8'hB8,
   parameter logic [WIDTH-1:0] SEED    = 8'h01,
   parameter int               NUM_VEC = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   stim_lfsr_gen_if.master     bus
);
   localparam int CNT_W = $clog2(NUM_VEC + 1);

   // An all-zero seed would lock the LFSR, so it is promoted to 1.
   localparam logic [WIDTH-1:0] SEED_E =
      (SEED == '0) ? WIDTH'(1) : SEED;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VEC);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] lfsr_d;
   logic [WIDTH-1:0] seed_d;
   logic [WIDTH-1:0] stim_q;
   logic             valid_q;
   logic             chk_q;
   logic             busy_q;
   logic             done_q;
   logic [CNT_W-1:0] count_q;

   function automatic logic [WIDTH-1:0] step(
      input logic [WIDTH-1:0] v
   );
      step = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
   endfunction

   assign lfsr_d = step(lfsr_q);
   assign seed_d = step(SEED_E);

   // Control FSM; every output comes straight from a register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         lfsr_q  <= SEED_E;
         stim_q  <= '0;
         valid_q <= 1'b0;
         chk_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= '0;
      end else begin
         chk_q <= valid_q;
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  stim_q  <= SEED_E;
                  lfsr_q  <= seed_d;
                  valid_q <= 1'b1;
                  count_q <= CNT_W'(1);
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  state_q <= S_RUN;
               end else begin
                  valid_q <= 1'b0;
               end
            end
            S_RUN: begin
               if (bus.hold) begin
                  valid_q <= 1'b0;
               end else if (count_q == LAST) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  stim_q  <= lfsr_q;
                  lfsr_q  <= lfsr_d;
                  valid_q <= 1'b1;
                  count_q <= count_q + 1'b1;
               end
            end
            default: begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.stim    = stim_q;
   assign bus.valid   = valid_q;
   assign bus.chk_stb = chk_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.count   = count_q;
endmodule
